// File: rtl/regbank_pkg.sv
// Shared types and helpers for the register bank: FSM states, per-bit
// access kinds and the byte-strobe expansion used on writes.
package regbank_pkg;

   // Widest data bus the strobe helper can expand; callers truncate the result.
   localparam int MAX_DATA_WIDTH = 1024;
   localparam int MAX_STRB_WIDTH = MAX_DATA_WIDTH / 8;

   typedef enum logic {
      IDLE = 1'b0,
      RESP = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      RW  = 2'd0,
      RO  = 2'd1,
      W1C = 2'd2
   } access_t;

   // Classify one storage bit from its RW and W1C mask bits.
   function automatic access_t accessKind(input logic rwBit, input logic w1cBit);
      access_t kind;
      if (w1cBit)
         kind = W1C;
      else if (rwBit)
         kind = RW;
      else
         kind = RO;
      return kind;
   endfunction

   // Expand one enable bit per byte into a per-bit mask.
   function automatic logic [MAX_DATA_WIDTH-1:0] byte_mask(input logic [MAX_STRB_WIDTH-1:0] wstrb);
      logic [MAX_DATA_WIDTH-1:0] mask;
      for (int b = 0; b < MAX_STRB_WIDTH; b++)
         mask[b*8 +: 8] = {8{wstrb[b]}};
      return mask;
   endfunction

endpackage

// File: rtl/regbank_if.sv
// Request/response bus between the bus adaptor (master) and the register bank (slave).
interface regbank_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4
);
   logic                    req_valid;
   logic                    req_ready;
   logic                    req_write;
   logic [ADDR_WIDTH-1:0]   req_addr;
   logic [DATA_WIDTH-1:0]   req_wdata;
   logic [DATA_WIDTH/8-1:0] req_wstrb;
   logic                    rsp_valid;
   logic                    rsp_ready;
   logic [DATA_WIDTH-1:0]   rsp_rdata;
   logic                    rsp_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/regbank_reg.sv
// One register of the bank: per-bit RW / W1C / RO behaviour, byte-masked bus
// writes, hardware set pulses for W1C bits and an optional reset.
module regbank_reg
   import regbank_pkg::*;
#(
   parameter int                    DATA_WIDTH  = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
   parameter bit                    RESET_EN    = 1'b1,
   parameter logic [DATA_WIDTH-1:0] RW_MASK     = '1,
   parameter logic [DATA_WIDTH-1:0] W1C_MASK    = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wrEn,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [DATA_WIDTH-1:0] wmask,
   input  logic [DATA_WIDTH-1:0] hwSet,
   output logic [DATA_WIDTH-1:0] q
);

   localparam logic [DATA_WIDTH-1:0] STORE_MASK = RW_MASK | W1C_MASK;

   logic [DATA_WIDTH-1:0] storage;
   logic [DATA_WIDTH-1:0] nextVal;

   // Per-bit next value; a hardware set on a W1C bit overrides a same-cycle bus clear.
   always_comb begin
      nextVal = storage;
      for (int b = 0; b < DATA_WIDTH; b++) begin
         case (accessKind(RW_MASK[b], W1C_MASK[b]))
            RW: begin
               if (wrEn && wmask[b])
                  nextVal[b] = wdata[b];
            end
            W1C: begin
               if (wrEn && wmask[b] && wdata[b])
                  nextVal[b] = 1'b0;
               if (hwSet[b])
                  nextVal[b] = 1'b1;
            end
            default: nextVal[b] = 1'b0;
         endcase
      end
   end

   // Storage update; registers without a reset simply hold while reset is high.
   always_ff @(posedge clk) begin
      if (reset) begin
         if (RESET_EN)
            storage <= RESET_VALUE & STORE_MASK;
      end else begin
         storage <= nextVal;
      end
   end

   assign q = storage & STORE_MASK;

endmodule

// File: rtl/regbank_ctrl.sv
// Control/status register bank behind a single-outstanding request/response
// bus. Holds the two-state handshake FSM, the read mux and the interrupt.
module regbank_ctrl
   import regbank_pkg::*;
#(
   parameter int                             DATA_WIDTH  = 32,
   parameter int                             ADDR_WIDTH  = 4,
   parameter int                             NUM_REGS    = 9,
   parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VALUE = '0,
   parameter logic [NUM_REGS-1:0]            RESET_EN    = '1,
   parameter logic [NUM_REGS*DATA_WIDTH-1:0] RW_MASK     = '1,
   parameter logic [NUM_REGS*DATA_WIDTH-1:0] W1C_MASK    = '0
) (
   input  logic                           clk,
   input  logic                           reset,
   regbank_if.slave                       bus,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_ro_in,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_set,
   output logic [NUM_REGS*DATA_WIDTH-1:0] regs_q,
   output logic                           irq
);

   localparam logic [ADDR_WIDTH:0] NUM_REGS_LIMIT = (ADDR_WIDTH+1)'(NUM_REGS);

   // Parameter sanity: a bit cannot be both RW and W1C, and every register needs an address.
   if ((RW_MASK & W1C_MASK) != '0) begin : gMaskOverlap
      $error("regbank_ctrl: RW_MASK and W1C_MASK overlap");
   end
   if (NUM_REGS > (2 ** ADDR_WIDTH)) begin : gAddrRange
      $error("regbank_ctrl: NUM_REGS does not fit in ADDR_WIDTH");
   end

   state_t                state;
   logic                  reqReady;
   logic                  rspValid;
   logic                  rspErr;
   logic                  irqQ;
   logic [DATA_WIDTH-1:0] rspRdata;
   logic [DATA_WIDTH-1:0] wMask;
   logic [DATA_WIDTH-1:0] readData;
   logic                  accept;
   logic                  inRange;
   logic [DATA_WIDTH-1:0] regQ    [NUM_REGS];
   logic [DATA_WIDTH-1:0] readVal [NUM_REGS];

   assign inRange = {1'b0, bus.req_addr} < NUM_REGS_LIMIT;
   assign accept  = (state == IDLE) && bus.req_valid;
   assign wMask   = DATA_WIDTH'(byte_mask(MAX_STRB_WIDTH'(bus.req_wstrb)));

   for (genvar i = 0; i < NUM_REGS; i++) begin : gReg
      regbank_reg #(
         .DATA_WIDTH (DATA_WIDTH),
         .RESET_VALUE(RESET_VALUE[i*DATA_WIDTH +: DATA_WIDTH]),
         .RESET_EN   (RESET_EN[i]),
         .RW_MASK    (RW_MASK[i*DATA_WIDTH +: DATA_WIDTH]),
         .W1C_MASK   (W1C_MASK[i*DATA_WIDTH +: DATA_WIDTH])
      ) uReg (
         .clk  (clk),
         .reset(reset),
         .wrEn (accept && bus.req_write && (bus.req_addr == ADDR_WIDTH'(i))),
         .wdata(bus.req_wdata),
         .wmask(wMask),
         .hwSet(hw_set[i*DATA_WIDTH +: DATA_WIDTH]),
         .q    (regQ[i])
      );

      assign regs_q[i*DATA_WIDTH +: DATA_WIDTH] = regQ[i];
      assign readVal[i] = regQ[i] | (hw_ro_in[i*DATA_WIDTH +: DATA_WIDTH] &
                          ~(RW_MASK[i*DATA_WIDTH +: DATA_WIDTH] | W1C_MASK[i*DATA_WIDTH +: DATA_WIDTH]));
   end

   // Read mux: out-of-range addresses fall through to zero.
   always_comb begin
      readData = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (bus.req_addr == ADDR_WIDTH'(i))
            readData = readVal[i];
      end
   end

   // Handshake FSM with registered bus outputs, plus the registered interrupt.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         reqReady <= 1'b1;
         rspValid <= 1'b0;
         rspRdata <= '0;
         rspErr   <= 1'b0;
         irqQ     <= 1'b0;
      end else begin
         irqQ <= |(regs_q & W1C_MASK);
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  state    <= RESP;
                  reqReady <= 1'b0;
                  rspValid <= 1'b1;
                  rspRdata <= bus.req_write ? '0 : readData;
                  rspErr   <= !inRange;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  state    <= IDLE;
                  reqReady <= 1'b1;
                  rspValid <= 1'b0;
                  rspRdata <= '0;
                  rspErr   <= 1'b0;
               end
            end
            default: begin
               state    <= IDLE;
               reqReady <= 1'b1;
               rspValid <= 1'b0;
            end
         endcase
      end
   end

   assign bus.req_ready = reqReady;
   assign bus.rsp_valid = rspValid;
   assign bus.rsp_rdata = rspRdata;
   assign bus.rsp_err   = rspErr;
   assign irq           = irqQ;

endmodule

// File: tb/tb_regbank_ctrl.sv
// Directed bench for regbank_ctrl: reset values, strobed writes, RO/W1C
// behaviour, interrupt timing, address errors, unreset registers and
// response back-pressure.
module tb_regbank_ctrl;

   localparam int DW = 32;
   localparam int AW = 4;
   localparam int NR = 9;

   // Reg 2 resets to 1, reg 4 has a reset value partly in RO bits.
   localparam logic [NR*DW-1:0] RV = {32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_00AA,
                                      32'h0, 32'h0000_0001, 32'h0, 32'h0};
   // Reg 5 is the only unreset register.
   localparam logic [NR-1:0]    REN = 9'b1_1101_1111;
   // Reg 4 upper half is RO; reg 3 low nibble is W1C.
   localparam logic [NR*DW-1:0] RWM = {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                       32'h0000_FFFF, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                       32'hFFFF_FFFF};
   localparam logic [NR*DW-1:0] W1M = {32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                       32'h0000_000F, 32'h0, 32'h0, 32'h0};

   logic             clk;
   logic             reset;
   logic [NR*DW-1:0] hwRoIn;
   logic [NR*DW-1:0] hwSet;
   logic [NR*DW-1:0] regsQ;
   logic             irq;
   int               passCount;
   int               checkCount;

   regbank_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   regbank_ctrl #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .NUM_REGS   (NR),
      .RESET_VALUE(RV),
      .RESET_EN   (REN),
      .RW_MASK    (RWM),
      .W1C_MASK   (W1M)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus),
      .hw_ro_in(hwRoIn),
      .hw_set  (hwSet),
      .regs_q  (regsQ),
      .irq     (irq)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case the run stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
   endtask

   // One bus transaction with hand-computed expected response; holdCycles keeps
   // rsp_ready low while a stray write to reg 1 is offered and must be ignored.
   task automatic applyStimulus(input string tag, input logic wr, input logic [AW-1:0] addr,
                                input logic [DW-1:0] wdata, input logic [DW/8-1:0] strb,
                                input int holdCycles, input logic [DW-1:0] expRdata, input logic expErr);
      int n;
      n = 0;
      while (bus.req_ready !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      if (n >= 20) checkOutput({tag, "_readyTimeout"}, 32'(bus.req_ready), 32'd1);
      bus.req_valid = 1'b1;
      bus.req_write = wr;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      bus.req_wstrb = strb;
      tick();
      bus.req_valid = 1'b0;
      checkOutput({tag, "_rspValid"}, 32'(bus.rsp_valid), 32'd1);
      checkOutput({tag, "_rdata"}, bus.rsp_rdata, expRdata);
      checkOutput({tag, "_err"}, 32'(bus.rsp_err), 32'(expErr));
      for (int h = 0; h < holdCycles; h++) begin
         bus.req_valid = 1'b1;
         bus.req_write = 1'b1;
         bus.req_addr  = 4'd1;
         bus.req_wdata = 32'hDEAD_BEEF;
         bus.req_wstrb = 4'hF;
         tick();
         checkOutput({tag, "_holdValid"}, 32'(bus.rsp_valid), 32'd1);
         checkOutput({tag, "_holdRdata"}, bus.rsp_rdata, expRdata);
         checkOutput({tag, "_holdReady"}, 32'(bus.req_ready), 32'd0);
      end
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      checkOutput({tag, "_rspDone"}, 32'(bus.rsp_valid), 32'd0);
   endtask

   // Directed test sequence.
   initial begin
      passCount     = 0;
      checkCount    = 0;
      reset         = 1'b1;
      hwSet         = '0;
      hwRoIn        = '0;
      hwRoIn[4*DW +: DW] = 32'hCAFE_5555;
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.req_wstrb = '0;
      bus.rsp_ready = 1'b0;
      tick();
      tick();
      checkOutput("rstReqReady", 32'(bus.req_ready), 32'd1);
      checkOutput("rstRspValid", 32'(bus.rsp_valid), 32'd0);
      checkOutput("rstRdata", bus.rsp_rdata, 32'd0);
      checkOutput("rstErr", 32'(bus.rsp_err), 32'd0);
      checkOutput("rstIrq", 32'(irq), 32'd0);
      checkOutput("rstReg2", regsQ[2*DW +: DW], 32'h1);
      checkOutput("rstReg4", regsQ[4*DW +: DW], 32'h0000_00AA);
      reset = 1'b0;
      $display("[TB] reset released");

      applyStimulus("readReg2", 1'b0, 4'd2, 32'h0, 4'h0, 0, 32'h1, 1'b0);
      applyStimulus("holdReg2", 1'b0, 4'd2, 32'h0, 4'h0, 5, 32'h1, 1'b0);
      applyStimulus("strayWrite", 1'b0, 4'd1, 32'h0, 4'h0, 0, 32'h0, 1'b0);

      applyStimulus("wrStrb", 1'b1, 4'd0, 32'hAABB_CCDD, 4'b0101, 0, 32'h0, 1'b0);
      applyStimulus("rdStrb", 1'b0, 4'd0, 32'h0, 4'h0, 0, 32'h00BB_00DD, 1'b0);

      applyStimulus("rdRo", 1'b0, 4'd4, 32'h0, 4'h0, 0, 32'hCAFE_00AA, 1'b0);
      applyStimulus("wrRo", 1'b1, 4'd4, 32'h1111_2222, 4'hF, 0, 32'h0, 1'b0);
      applyStimulus("rdRo2", 1'b0, 4'd4, 32'h0, 4'h0, 0, 32'hCAFE_2222, 1'b0);

      // Hardware set of a W1C bit, interrupt one cycle after the bit.
      hwSet[3*DW + 2] = 1'b1;
      tick();
      hwSet[3*DW + 2] = 1'b0;
      checkOutput("w1cSetBit", regsQ[3*DW +: DW], 32'h4);
      checkOutput("irqLag", 32'(irq), 32'd0);
      tick();
      checkOutput("irqSet", 32'(irq), 32'd1);
      applyStimulus("w1cClear", 1'b1, 4'd3, 32'h4, 4'hF, 0, 32'h0, 1'b0);
      checkOutput("w1cCleared", regsQ[3*DW +: DW], 32'h0);
      checkOutput("irqCleared", 32'(irq), 32'd0);

      // Set and clear on the same edge: the set wins.
      hwSet[3*DW + 2] = 1'b1;
      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
      bus.req_addr  = 4'd3;
      bus.req_wdata = 32'h4;
      bus.req_wstrb = 4'hF;
      tick();
      hwSet[3*DW + 2] = 1'b0;
      bus.req_valid = 1'b0;
      checkOutput("setWins", regsQ[3*DW +: DW], 32'h4);
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      checkOutput("setWinsIrq", 32'(irq), 32'd1);
      applyStimulus("rdW1c", 1'b0, 4'd3, 32'h0, 4'h0, 0, 32'h4, 1'b0);

      applyStimulus("rdOob", 1'b0, 4'd12, 32'h0, 4'h0, 0, 32'h0, 1'b1);
      applyStimulus("wrOob", 1'b1, 4'd12, 32'hFFFF_FFFF, 4'hF, 0, 32'h0, 1'b1);
      checkOutput("oobReg4", regsQ[4*DW +: DW], 32'h0000_2222);
      checkOutput("oobReg0", regsQ[0 +: DW], 32'h00BB_00DD);
      checkOutput("oobReg1", regsQ[1*DW +: DW], 32'h0);

      // Unreset register survives reset; others return to their reset values.
      applyStimulus("wrReg5", 1'b1, 4'd5, 32'h0000_005A, 4'hF, 0, 32'h0, 1'b0);
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      checkOutput("rstIrq2", 32'(irq), 32'd0);
      applyStimulus("rdReg5", 1'b0, 4'd5, 32'h0, 4'h0, 0, 32'h0000_005A, 1'b0);
      applyStimulus("rdReg0Rst", 1'b0, 4'd0, 32'h0, 4'h0, 0, 32'h0, 1'b0);
      applyStimulus("rdReg4Rst", 1'b0, 4'd4, 32'h0, 4'h0, 0, 32'hCAFE_00AA, 1'b0);

      // Reset while a response is pending.
      bus.req_valid = 1'b1;
      bus.req_write = 1'b0;
      bus.req_addr  = 4'd2;
      tick();
      bus.req_valid = 1'b0;
      checkOutput("pendValid", 32'(bus.rsp_valid), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkOutput("pendDropped", 32'(bus.rsp_valid), 32'd0);
      checkOutput("pendReady", 32'(bus.req_ready), 32'd1);
      tick();
      checkOutput("pendIdle", 32'(bus.rsp_valid), 32'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
